dac_cfg_sequencer: RTL and testbench
====================================

// Module: dac_cfg_sequencer
// PURPOSE
//  Consumes the 4-bit addr/data pair driven by the JTAG AXI-lite adapter and turns it
//  into a committed tuning word for the MASH 1-1 DAC modulator. The adapter outputs
//  carry no strobe, so a write is a new {addr,data} pair held stable for STABLE_CYCLES.
//  Nibbles collect in a shadow bank. A commit key transfers the bank to the modulator
//  over a valid/ready handshake.
// PARAMETERS
//  NIB_COUNT      6      tuning-word nibbles; word width TW = 4*NIB_COUNT (24)
//  STABLE_CYCLES  4      cycles a new pair must hold before it counts as a write (>=2)
//  COMMIT_ADDR    4'hF   control address (commit / clear)
// PORTS
//  aclk          in   1     single clock; all logic on rising edge
//  rst           in   1     synchronous, active-high reset
//  cfg_addr      in   4     address nibble from adapter (aclk domain)
//  cfg_data      in   4     data nibble from adapter (aclk domain)
//  m_tune_data   out  TW    committed tuning word; nibble i = bits [4i+3:4i]
//  m_tune_valid  out  1     tuning word offered to modulator
//  m_tune_ready  in   1     modulator accepts word
//  busy          out  1     high in OFFER state or while a commit is pending
//  err_addr      out  1     sticky flag: a write went to an unmapped address
//  commit_count  out  8     only with DAC_CFG_STATUS_EN: handshakes completed
// BEHAVIOUR
//  - Reset: every output is 0. Shadow bank, pair register, counter and pending flag are 0. FSM goes to IDLE.
//  - Input pair is registered once (pair_q). Stability counter:
//    - It clears to 0 when pair_q != the previous pair_q.
//    - Otherwise it increments, saturating at STABLE_CYCLES.
//    - wr_pulse fires for 1 cycle when the counter goes from STABLE_CYCLES-1 to STABLE_CYCLES.
//    - Latency: a change on the inputs gives wr_pulse STABLE_CYCLES+1 edges later.
//  - The reset value {0,0} is pre-armed. The counter resets to STABLE_CYCLES with no pulse, so only a change can create a write.
//    Repeating the same pair never re-fires. To commit twice the host must write a different pair in between.
//  - Write decode on wr_pulse:
//    - addr < NIB_COUNT: shadow[addr] <= data.
//    - addr == COMMIT_ADDR, data == COMMIT_KEY (4'hA): commit request.
//    - addr == COMMIT_ADDR, data == CLEAR_KEY (4'h0): err_addr <= 0.
//    - addr == COMMIT_ADDR, any other data: ignored.
//    - Any other addr: err_addr <= 1 (sticky). Shadow is unchanged.
//  - FSM IDLE/OFFER:
//    - IDLE + commit: m_tune_data <= shadow bank; m_tune_valid goes 1 on the next edge; go to OFFER.
//    - OFFER: m_tune_data and m_tune_valid stay stable until m_tune_valid & m_tune_ready. Then valid drops and the FSM returns to IDLE.
//    - Commit during OFFER sets pending. pending is not cumulative: one pending max.
//    - IDLE with pending: reload from shadow, clear pending, re-enter OFFER.
//      So the second offer begins 1 cycle after the handshake.
//    - Shadow writes during OFFER are allowed and do not disturb m_tune_data.
//    - Ready while IDLE is ignored. No combinational path from ready to valid.
//  - Reset mid-OFFER: valid is 0 after that edge. The offered word is lost and no handshake counts.
// CONFIGURATION
//  - DAC_CFG_STATUS_EN defined:
//    - commit_count is present and resets to 0.
//    - It increments by 1 on each valid&ready handshake.
//    - It wraps from 255 to 0.
//  - Not defined: the port is absent and there is no counter logic.
// STRUCTURE
//  - Package dac_cfg_pkg holds:
//    - NIB_W = 4
//    - COMMIT_KEY = 4'hA, CLEAR_KEY = 4'h0
//    - typedef enum logic {IDLE, OFFER} cfg_state_t
//    - typedef struct {addr, data} cfg_pair_t
//  - Sub-module cfg_stable_detect: pair register + stability counter + wr_pulse.
//    Parameterised by STABLE_CYCLES. Instantiated once.
// TESTING
//  1. Reset, then drive nibbles 1..6 to addrs 0..5, then {F,A}, ready=1:
//     valid for exactly 1 cycle, m_tune_data = 24'h654321.
//  2. Pair held STABLE_CYCLES-1 cycles, then changed: no write. Shadow and outputs unchanged.
//  3. Commit with ready=0 for 10 cycles:
//     valid and data are held for 10 cycles. Writing addr0=F during this time does not change data.
//     Then ready=1 gives a handshake.
//  4. Commit, then {F,0}, then {F,A} while in OFFER, then assert ready:
//     two back-to-back offers, with the second one reloaded from shadow.
//     busy is high throughout.
//  5. Write to addr 7: err_addr=1 and shadow unchanged. Then {F,0}: err_addr=0.
//  6. rst pulsed while in OFFER: all outputs 0 next cycle. With DAC_CFG_STATUS_EN, 256 handshakes return commit_count to 0.

Source files
------------

// File: rtl/dac_cfg_pkg.sv
// Shared types and constants for the DAC tuning-word configuration sequencer.
package dac_cfg_pkg;

  localparam int NIB_W = 4;

  localparam logic [NIB_W-1:0] COMMIT_KEY = 4'hA;
  localparam logic [NIB_W-1:0] CLEAR_KEY  = 4'h0;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } cfg_state_t;

  typedef struct packed {
    logic [NIB_W-1:0] addr;
    logic [NIB_W-1:0] data;
  } cfg_pair_t;

endpackage

// File: rtl/cfg_stable_detect.sv
// Turns the strobeless adapter addr/data pair into a one-cycle write pulse once
// a new pair has been held stable long enough. The reset pair {0,0} is treated
// as already written, so only a change on the inputs can produce a write.
module cfg_stable_detect
  import dac_cfg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic             aclk,
  input  logic             rst,
  input  logic [NIB_W-1:0] addr_i,
  input  logic [NIB_W-1:0] data_i,
  output logic [NIB_W-1:0] addr_o,
  output logic [NIB_W-1:0] data_o,
  output logic             wr_pulse_o
);

  localparam int               CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(STABLE_CYCLES - 1);

  cfg_pair_t        pair_q;
  cfg_pair_t        prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             same;

  assign same = (pair_q == prev_q);

  // Stability counter: restart on any change, otherwise count up and saturate.
  always_comb begin
    cnt_d = cnt_q;
    if (!same) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_SAT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Input pair register, its one-cycle history and the counter.
  always_ff @(posedge aclk) begin
    if (rst) begin
      pair_q <= '0;
      prev_q <= '0;
      cnt_q  <= CNT_SAT;
    end else begin
      pair_q <= cfg_pair_t'({addr_i, data_i});
      prev_q <= pair_q;
      cnt_q  <= cnt_d;
    end
  end

  assign wr_pulse_o = same && (cnt_q == CNT_ARM);
  assign addr_o     = pair_q.addr;
  assign data_o     = pair_q.data;

endmodule

// File: rtl/dac_cfg_sequencer.sv
// Collects tuning-word nibbles from the JTAG adapter into a shadow bank and
// offers the committed word to the MASH 1-1 modulator over valid/ready.
// Optional build macro DAC_CFG_STATUS_EN adds the commit_count status port.
//
//   state | meaning
//   IDLE  | no word offered; a commit or pending request loads the shadow bank
//   OFFER | m_tune_data/m_tune_valid held until the modulator takes the word
module dac_cfg_sequencer
  import dac_cfg_pkg::*;
#(
  parameter int               NIB_COUNT     = 6,
  parameter int               STABLE_CYCLES = 4,
  parameter logic [NIB_W-1:0] COMMIT_ADDR   = 4'hF
) (
`ifdef DAC_CFG_STATUS_EN
  output logic [7:0]             commit_count,
`endif
  input  logic                   aclk,
  input  logic                   rst,
  input  logic [NIB_W-1:0]       cfg_addr,
  input  logic [NIB_W-1:0]       cfg_data,
  output logic [NIB_W*NIB_COUNT-1:0] m_tune_data,
  output logic                   m_tune_valid,
  input  logic                   m_tune_ready,
  output logic                   busy,
  output logic                   err_addr
);

  localparam int               TW        = NIB_W * NIB_COUNT;
  localparam logic [NIB_W-1:0] NIB_LIMIT = NIB_W'(NIB_COUNT);

  logic [NIB_W-1:0] wr_addr;
  logic [NIB_W-1:0] wr_data;
  logic             wr_pulse;

  cfg_stable_detect #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_stable (
    .aclk      (aclk),
    .rst       (rst),
    .addr_i    (cfg_addr),
    .data_i    (cfg_data),
    .addr_o    (wr_addr),
    .data_o    (wr_data),
    .wr_pulse_o(wr_pulse)
  );

  logic [NIB_COUNT-1:0][NIB_W-1:0] shadow_q;
  logic [NIB_COUNT-1:0][NIB_W-1:0] shadow_d;
  logic                            err_q;
  logic                            err_d;
  logic                            commit_req;

  // Write decode: shadow nibbles, commit/clear keys, unmapped-address flag.
  always_comb begin
    shadow_d   = shadow_q;
    err_d      = err_q;
    commit_req = 1'b0;
    if (wr_pulse) begin
      if (wr_addr < NIB_LIMIT) begin
        for (int i = 0; i < NIB_COUNT; i++) begin
          if (wr_addr == NIB_W'(i)) shadow_d[i] = wr_data;
        end
      end else if (wr_addr == COMMIT_ADDR) begin
        if (wr_data == COMMIT_KEY) begin
          commit_req = 1'b1;
        end else if (wr_data == CLEAR_KEY) begin
          err_d = 1'b0;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Shadow bank and sticky error flag.
  always_ff @(posedge aclk) begin
    if (rst) begin
      shadow_q <= '0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      err_q    <= err_d;
    end
  end

  cfg_state_t    state_q;
  cfg_state_t    state_d;
  logic          pending_q;
  logic          pending_d;
  logic          load;
  logic [TW-1:0] word_q;

  // State register with the offered word and the single pending commit.
  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      word_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      if (load) word_q <= shadow_q;
    end
  end

  // Next state: a commit seen mid-offer is remembered once and replayed from IDLE.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        if (commit_req || pending_q) begin
          load      = 1'b1;
          pending_d = 1'b0;
          state_d   = OFFER;
        end
      end
      OFFER: begin
        if (commit_req) pending_d = 1'b1;
        if (m_tune_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend on registered state only, never on ready.
  always_comb begin
    m_tune_valid = (state_q == OFFER);
    busy         = (state_q == OFFER) || pending_q;
  end

  assign m_tune_data = word_q;
  assign err_addr    = err_q;

`ifdef DAC_CFG_STATUS_EN
  logic [7:0] count_q;

  // Completed handshakes, wrapping at 256.
  always_ff @(posedge aclk) begin
    if (rst) begin
      count_q <= 8'd0;
    end else if ((state_q == OFFER) && m_tune_ready) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign commit_count = count_q;
`endif

endmodule

// File: tb/tb_dac_cfg_sequencer.sv
// Randomized self-checking bench for dac_cfg_sequencer with a transaction-level
// model of the shadow bank, error flag and offered words.
module tb_dac_cfg_sequencer;

  localparam int S  = 4;
  localparam int NC = 6;

  logic        aclk = 1'b0;
  logic        rst;
  logic [3:0]  cfg_addr;
  logic [3:0]  cfg_data;
  logic [23:0] m_tune_data;
  logic        m_tune_valid;
  logic        m_tune_ready;
  logic        busy;
  logic        err_addr;
`ifdef DAC_CFG_STATUS_EN
  logic [7:0]  commit_count;
`endif

  dac_cfg_sequencer dut (
`ifdef DAC_CFG_STATUS_EN
    .commit_count(commit_count),
`endif
    .aclk        (aclk),
    .rst         (rst),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .m_tune_data (m_tune_data),
    .m_tune_valid(m_tune_valid),
    .m_tune_ready(m_tune_ready),
    .busy        (busy),
    .err_addr    (err_addr)
  );

  always #5 aclk = ~aclk;

  int         n_chk = 0;
  int         n_err = 0;
  logic [3:0] shadow_m [NC];
  logic       err_m;
  logic [7:0] last_pair;
  int         hs_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  function automatic logic [23:0] exp_word();
    logic [23:0] w;
    for (int i = 0; i < NC; i++) w[4*i +: 4] = shadow_m[i];
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NC; i++) shadow_m[i] = 4'h0;
    err_m     = 1'b0;
    last_pair = 8'h00;
    hs_cnt    = 0;
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] d, input int h);
    cfg_addr  = a;
    cfg_data  = d;
    last_pair = {a, d};
    cyc(h);
  endtask

  // Short hold: must never be taken as a write.
  task automatic glitch(input logic [3:0] a, input logic [3:0] d);
    if ({a, d} == last_pair) return;
    drive(a, d, $urandom_range(1, S - 1));
  endtask

  // Real write; a repeat of the previous pair is separated by a brief other pair.
  task automatic wr(input logic [3:0] a, input logic [3:0] d);
    if ({a, d} == last_pair) drive(a, d ^ 4'h1, 1);
    drive(a, d, S + 1 + $urandom_range(0, 2));
    if (a < 4'(NC)) shadow_m[int'(a)] = d;
    else if (a == 4'hF) begin
      if (d == 4'h0) err_m = 1'b0;
    end else err_m = 1'b1;
    cyc(1);
    chk("err_addr", {31'b0, err_addr}, {31'b0, err_m});
  endtask

  task automatic check_count();
`ifdef DAC_CFG_STATUS_EN
    chk("commit_count", {24'b0, commit_count}, 32'(hs_cnt % 256));
`endif
  endtask

  // Issue the commit key and wait (bounded) for the offer; checks offered word.
  task automatic commit_start();
    logic [23:0] w;
    bit          ok;
    w  = exp_word();
    ok = 1'b0;
    if (last_pair == 8'hFA) drive(4'hF, 4'h5, 1);
    drive(4'hF, 4'hA, S + 1);
    for (int i = 0; i < 20; i++) begin
      if (m_tune_valid) begin
        ok = 1'b1;
        break;
      end
      cyc(1);
    end
    chk("offer_seen", {31'b0, ok}, 32'd1);
    chk("offer_data", {8'b0, m_tune_data}, {8'b0, w});
    chk("offer_busy", {31'b0, busy}, 32'd1);
  endtask

  task automatic commit_offer(input int k);
    logic [23:0] w;
    m_tune_ready = 1'b0;
    w = exp_word();
    commit_start();
    for (int i = 0; i < k; i++) begin
      cyc(1);
      chk("hold_valid", {31'b0, m_tune_valid}, 32'd1);
      chk("hold_data", {8'b0, m_tune_data}, {8'b0, w});
    end
    m_tune_ready = 1'b1;
    cyc(1);
    m_tune_ready = 1'b0;
    hs_cnt++;
    chk("hs_valid_drop", {31'b0, m_tune_valid}, 32'd0);
    chk("hs_busy_drop", {31'b0, busy}, 32'd0);
    check_count();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [23:0] w1;
    logic [23:0] w2;
    logic [3:0]  d;
    int          sel;

    rst = 1'b1; cfg_addr = 4'h0; cfg_data = 4'h0; m_tune_ready = 1'b0;
    model_reset();
    cyc(3);
    chk("rst_valid", {31'b0, m_tune_valid}, 32'd0);
    chk("rst_data", {8'b0, m_tune_data}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_err", {31'b0, err_addr}, 32'd0);
    check_count();
    rst = 1'b0;
    cyc(12);
    chk("prearm_no_write", {31'b0, m_tune_valid | err_addr | busy}, 32'd0);

    // Nibbles 1..6, then commit with ready already high.
    for (int i = 0; i < NC; i++) wr(4'(i), 4'(i + 1));
    m_tune_ready = 1'b1;
    commit_start();
    chk("t1_word", {8'b0, m_tune_data}, 32'h654321);
    cyc(1);
    hs_cnt++;
    chk("t1_one_cycle", {31'b0, m_tune_valid}, 32'd0);
    cyc(3);
    chk("t1_stays_idle", {31'b0, m_tune_valid}, 32'd0);
    m_tune_ready = 1'b0;
    check_count();

    // Pairs held too briefly are not writes.
    glitch(4'h0, 4'h9);
    glitch(4'h7, 4'h3);
    glitch(4'hF, 4'hA);
    glitch(4'h2, 4'hC);
    cyc(1);
    chk("t2_err", {31'b0, err_addr}, 32'd0);
    chk("t2_valid", {31'b0, m_tune_valid}, 32'd0);

    // Long hold with ready low, shadow write during the offer.
    m_tune_ready = 1'b0;
    w1 = exp_word();
    commit_start();
    cfg_addr = 4'h0; cfg_data = 4'hF; last_pair = 8'h0F;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("t3_valid", {31'b0, m_tune_valid}, 32'd1);
      chk("t3_data", {8'b0, m_tune_data}, {8'b0, w1});
    end
    shadow_m[0] = 4'hF;
    m_tune_ready = 1'b1;
    cyc(1);
    m_tune_ready = 1'b0;
    hs_cnt++;
    chk("t3_handshake", {31'b0, m_tune_valid}, 32'd0);
    check_count();

    // Second commit during the offer: back-to-back offers.
    w1 = exp_word();
    commit_start();
    wr(4'hF, 4'h0);
    chk("t4_busy_a", {31'b0, busy}, 32'd1);
    wr(4'h1, 4'(($urandom_range(1, 15) + 32'(shadow_m[1])) % 16));
    w2 = exp_word();
    cfg_addr = 4'hF; cfg_data = 4'hA; last_pair = 8'hFA;
    for (int i = 0; i < S + 3; i++) begin
      cyc(1);
      chk("t4_busy_b", {31'b0, busy}, 32'd1);
      chk("t4_first_data", {8'b0, m_tune_data}, {8'b0, w1});
    end
    m_tune_ready = 1'b1;
    cyc(1);
    chk("t4_gap_valid", {31'b0, m_tune_valid}, 32'd0);
    chk("t4_gap_busy", {31'b0, busy}, 32'd1);
    cyc(1);
    chk("t4_second_valid", {31'b0, m_tune_valid}, 32'd1);
    chk("t4_second_data", {8'b0, m_tune_data}, {8'b0, w2});
    cyc(1);
    m_tune_ready = 1'b0;
    hs_cnt += 2;
    chk("t4_done_valid", {31'b0, m_tune_valid}, 32'd0);
    chk("t4_done_busy", {31'b0, busy}, 32'd0);
    check_count();

    // Unmapped address sets sticky error and leaves the shadow alone.
    wr(4'h7, 4'($urandom_range(0, 15)));
    commit_offer(2);
    chk("t5_err_sticky", {31'b0, err_addr}, 32'd1);
    wr(4'hF, 4'h0);

    // Randomized traffic.
    for (int it = 0; it < 25; it++) begin
      for (int n = $urandom_range(1, 5); n > 0; n--) begin
        sel = $urandom_range(0, 99);
        if (sel < 65) wr(4'($urandom_range(0, NC - 1)), 4'($urandom_range(0, 15)));
        else if (sel < 80) wr(4'($urandom_range(NC, 14)), 4'($urandom_range(0, 15)));
        else if (sel < 90) begin
          d = 4'($urandom_range(0, 14));
          if (d >= 4'hA) d = d + 4'h1;
          wr(4'hF, d);
        end else glitch(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end
      if ($urandom_range(0, 3) == 0) begin
        m_tune_ready = 1'b1;
        cyc(2);
        m_tune_ready = 1'b0;
        chk("idle_ready_ignored", {31'b0, m_tune_valid}, 32'd0);
      end
      commit_offer($urandom_range(0, 6));
    end

    // Reset in the middle of an offer.
    m_tune_ready = 1'b0;
    commit_start();
    rst = 1'b1; cfg_addr = 4'h0; cfg_data = 4'h0;
    cyc(1);
    model_reset();
    chk("t6_valid", {31'b0, m_tune_valid}, 32'd0);
    chk("t6_data", {8'b0, m_tune_data}, 32'd0);
    chk("t6_busy", {31'b0, busy}, 32'd0);
    chk("t6_err", {31'b0, err_addr}, 32'd0);
    check_count();
    rst = 1'b0;
    cyc(8);
    chk("t6_no_replay", {31'b0, m_tune_valid}, 32'd0);
    commit_offer(1);

`ifdef DAC_CFG_STATUS_EN
    m_tune_ready = 1'b1;
    for (int i = 0; i < 255; i++) begin
      drive(4'hF, 4'h5, 1);
      drive(4'hF, 4'hA, S + 3);
      hs_cnt++;
      check_count();
    end
    m_tune_ready = 1'b0;
    chk("count_wrap", {24'b0, commit_count}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
